// File: rtl/dct_1d_stream_if.sv
// Sample-in / coefficient-out stream bundle for dct_1d_stream.
// master drives samples and out_ready; slave is the transform block.
interface dct_1d_stream_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 12
);
  logic [DATA_W-1:0]       in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [OUT_W-1:0] out_data;
  logic [2:0]              out_index;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_index, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_index, out_last, out_valid
  );
endinterface

// File: rtl/dct_1d_stream.sv
// Streaming 8-point orthonormal DCT-II: buffers 8 samples, then runs one
// time-shared MAC per coefficient and hands X0..X7 out with backpressure.
module dct_1d_stream #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned COEF_W      = 14,
  parameter int unsigned OUT_W       = 12,
  parameter bit          LEVEL_SHIFT = 1'b1
) (
  input logic             clk_i,
  input logic             reset_i,
  input logic             en_i,
  dct_1d_stream_if.slave  strm_io
);
  localparam int unsigned SAMP_W    = DATA_W + 1;
  localparam int unsigned PROD_W    = SAMP_W + COEF_W;
  localparam int unsigned ACC_W     = DATA_W + COEF_W + 4;
  localparam int unsigned HalfRange = 1 << (DATA_W - 1);
  localparam int          OutMaxI   = (1 << (OUT_W - 1)) - 1;
  localparam int          OutMinI   = -(1 << (OUT_W - 1));
  localparam logic signed [ACC_W-1:0] RoundAdd = ACC_W'(1 << (COEF_W - 2));

  typedef enum logic [1:0] {StLoad, StCalc, StEmit} state_e;

  // Elaboration-time ROM value, rounded half away from zero.
  function automatic int coef_calc(input int k, input int n);
    real ck;
    real v;
    ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    v  = 0.5 * ck * $cos(real'((2 * n + 1) * k) * 3.14159265358979323846 / 16.0)
         * (2.0 ** (COEF_W - 1));
    if (v >= 0.0) return int'($floor(v + 0.5));
    return -int'($floor(-v + 0.5));
  endfunction

  logic signed [COEF_W-1:0] coef_rom [64];
  for (genvar gi = 0; gi < 64; gi++) begin : g_rom
    localparam int CoefVal = coef_calc(gi / 8, gi % 8);
    assign coef_rom[gi] = COEF_W'(CoefVal);
  end

  state_e                   state_q, state_d;
  logic [2:0]               cnt_q, cnt_d, k_q, k_d, n_q, n_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic [2:0]               out_index_q, out_index_d;
  logic                     out_last_q, out_last_d;
  logic signed [SAMP_W-1:0] buf_q [8];
  logic                     buf_we;

  logic signed [SAMP_W-1:0] samp_shifted;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum, rnd;
  logic signed [OUT_W-1:0]  sat;
  logic                     accept;

  always_comb begin
    if (LEVEL_SHIFT) samp_shifted = $signed({1'b0, strm_io.in_data} - SAMP_W'(HalfRange));
    else             samp_shifted = $signed({strm_io.in_data[DATA_W-1], strm_io.in_data});
  end

  assign prod = PROD_W'(buf_q[n_q]) * PROD_W'(coef_rom[{k_q, n_q}]);
  assign sum  = acc_q + ACC_W'(prod);
  assign rnd  = (sum + RoundAdd) >>> (COEF_W - 1);

  always_comb begin
    if (rnd > ACC_W'(OutMaxI))      sat = OUT_W'(OutMaxI);
    else if (rnd < ACC_W'(OutMinI)) sat = OUT_W'(OutMinI);
    else                            sat = rnd[OUT_W-1:0];
  end

  // Reset also gates ready so nothing is taken while the block is being cleared.
  assign strm_io.in_ready  = en_i && !reset_i && (state_q == StLoad);
  assign strm_io.out_valid = en_i && (state_q == StEmit);
  assign strm_io.out_data  = out_data_q;
  assign strm_io.out_index = out_index_q;
  assign strm_io.out_last  = out_last_q;
  assign accept            = strm_io.in_valid && strm_io.in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    n_d         = n_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    buf_we      = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (accept) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = StCalc;
            k_d     = 3'd0;
            n_d     = 3'd0;
            acc_d   = '0;
          end
        end
      end
      StCalc: begin
        acc_d = sum;
        n_d   = n_q + 3'd1;
        if (n_q == 3'd7) begin
          out_data_d  = sat;
          out_index_d = k_q;
          out_last_d  = (k_q == 3'd7);
          state_d     = StEmit;
        end
      end
      StEmit: begin
        if (strm_io.out_ready) begin
          if (k_q == 3'd7) begin
            state_d = StLoad;
            k_d     = 3'd0;
          end else begin
            state_d = StCalc;
            k_d     = k_q + 3'd1;
            n_d     = 3'd0;
            acc_d   = '0;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StLoad;
      cnt_q       <= '0;
      k_q         <= '0;
      n_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else if (en_i) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      n_q         <= n_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
    end
  end

  // Sample store needs no reset: the counter restarting at 0 discards old contents.
  always_ff @(posedge clk_i) begin
    if (buf_we) buf_q[cnt_q] <= samp_shifted;
  end
endmodule

// File: tb/tb_dct_1d_stream.sv
// Self-checking bench: three lockstep instances (default, OUT_W=9, LEVEL_SHIFT=0)
// checked against a real-arithmetic DCT reference.
module tb_dct_1d_stream;
  localparam int  CoefW = 14;
  localparam real Pi    = 3.14159265358979323846;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;

  always #5 clk = ~clk;

  dct_1d_stream_if #(.DATA_W(8), .OUT_W(12)) if_a ();
  dct_1d_stream_if #(.DATA_W(8), .OUT_W(9))  if_b ();
  dct_1d_stream_if #(.DATA_W(8), .OUT_W(12)) if_c ();

  assign if_a.in_data = in_data;  assign if_a.in_valid = in_valid;  assign if_a.out_ready = out_ready;
  assign if_b.in_data = in_data;  assign if_b.in_valid = in_valid;  assign if_b.out_ready = out_ready;
  assign if_c.in_data = in_data;  assign if_c.in_valid = in_valid;  assign if_c.out_ready = out_ready;

  dct_1d_stream #(.DATA_W(8), .COEF_W(14), .OUT_W(12), .LEVEL_SHIFT(1'b1)) u_dut_a (
    .clk_i(clk), .reset_i(rst), .en_i(en), .strm_io(if_a.slave));
  dct_1d_stream #(.DATA_W(8), .COEF_W(14), .OUT_W(9), .LEVEL_SHIFT(1'b1)) u_dut_b (
    .clk_i(clk), .reset_i(rst), .en_i(en), .strm_io(if_b.slave));
  dct_1d_stream #(.DATA_W(8), .COEF_W(14), .OUT_W(12), .LEVEL_SHIFT(1'b0)) u_dut_c (
    .clk_i(clk), .reset_i(rst), .en_i(en), .strm_io(if_c.slave));

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_total = 0;
  int first_acc_cyc = 0;
  int last_acc_cyc = 0;
  int ready_cnt = 0;
  int mon_k = 0;
  int mdl_cnt = 0;
  int mdl_buf [8];
  int exp_a [$];
  int exp_b [$];
  int exp_c [$];
  bit rand_mode = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // X[k] from the defining formula with the rounded integer coefficient table.
  function automatic int model_x(input int k, input int xs [8], input int out_w);
    real    ck, cv;
    longint ci, acc, r, lim;
    acc = 0;
    ck  = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    for (int n = 0; n < 8; n++) begin
      cv  = 0.5 * ck * $cos(Pi * real'((2 * n + 1) * k) / 16.0) * real'(1 << (CoefW - 1));
      ci  = (cv >= 0.0) ? longint'($floor(cv + 0.5)) : -longint'($floor(-cv + 0.5));
      acc += ci * longint'(xs[n]);
    end
    r   = (acc + longint'(1 << (CoefW - 2))) >>> (CoefW - 1);
    lim = longint'(1) << (out_w - 1);
    if (r > lim - 1) r = lim - 1;
    if (r < -lim) r = -lim;
    return int'(r);
  endfunction

  task automatic push_expected();
    int xs_ls [8];
    int xs_raw [8];
    logic [7:0] b;
    for (int n = 0; n < 8; n++) begin
      b         = mdl_buf[n][7:0];
      xs_ls[n]  = mdl_buf[n] - 128;
      xs_raw[n] = int'($signed(b));
    end
    for (int k = 0; k < 8; k++) begin
      exp_a.push_back(model_x(k, xs_ls, 12));
      exp_b.push_back(model_x(k, xs_ls, 9));
      exp_c.push_back(model_x(k, xs_raw, 12));
    end
  endtask

  // One clock: settle inputs, score the handshakes about to fire, advance to next negedge.
  task automatic tick();
    if (rand_mode) begin
      out_ready = ($urandom_range(3) != 0);
      en        = ($urandom_range(9) != 0);
    end
    #1;
    if (rst) begin
      mdl_cnt = 0;
      mon_k   = 0;
      exp_a.delete();
      exp_b.delete();
      exp_c.delete();
    end else begin
      if (if_a.in_ready) ready_cnt++;
      if (in_valid && if_a.in_ready) begin
        mdl_buf[mdl_cnt] = int'(in_data);
        mdl_cnt++;
        acc_total++;
        if (mdl_cnt == 1) first_acc_cyc = cyc;
        if (mdl_cnt == 8) begin
          push_expected();
          mdl_cnt      = 0;
          last_acc_cyc = cyc;
        end
      end
      if (if_a.out_valid && out_ready) begin
        if (exp_a.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          check($sformatf("x%0d_a", mon_k), int'(if_a.out_data), exp_a.pop_front());
          check($sformatf("x%0d_b", mon_k), int'(if_b.out_data), exp_b.pop_front());
          check($sformatf("x%0d_c", mon_k), int'(if_c.out_data), exp_c.pop_front());
          check("index", int'(if_a.out_index), mon_k);
          check("last", int'(if_a.out_last), int'(mon_k == 7));
          check("valid_bc", int'(if_b.out_valid && if_c.out_valid), 1);
          mon_k = (mon_k + 1) % 8;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send_samples(input int s [8], input int first, input int num, input int gap_pct);
    int start;
    int guard;
    for (int i = first; i < first + num; i++) begin
      start   = acc_total;
      guard   = 0;
      in_data = s[i][7:0];
      while (acc_total == start && guard < 500) begin
        in_valid = ($urandom_range(99) >= gap_pct);
        tick();
        guard++;
      end
      if (acc_total == start) check("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_index(input int idx);
    int guard = 0;
    while (!(if_a.out_valid && int'(if_a.out_index) == idx) && guard < 600) begin
      tick();
      guard++;
    end
    if (guard >= 600) check($sformatf("wait_x%0d_timeout", idx), 0, 1);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_a.size() != 0 && guard < 3000) begin
      tick();
      guard++;
    end
    check("drain", exp_a.size(), 0);
  endtask

  int s228 [8] = '{228, 228, 228, 228, 228, 228, 228, 228};
  int s128 [8] = '{128, 128, 128, 128, 128, 128, 128, 128};
  int s255 [8] = '{255, 255, 255, 255, 255, 255, 255, 255};
  int s000 [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
  int sramp [8] = '{0, 1, 2, 3, 4, 5, 6, 7};

  initial begin
    int srnd [8];
    int prev_last;
    int hold;
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", int'(if_a.out_valid), 0);
    check("rst_in_ready", int'(if_a.in_ready), 0);
    check("rst_out_data", int'(if_a.out_data), 0);
    check("rst_out_index", int'(if_a.out_index), 0);
    check("rst_out_last", int'(if_a.out_last), 0);
    tick();
    rst = 1'b0;
    #1 check("rel_in_ready", int'(if_a.in_ready), 1);

    // Constant 228 block and first-output latency.
    send_samples(s228, 0, 8, 20);
    wait_index(0);
    check("s1_latency", cyc - last_acc_cyc, 9);
    check("s1_x0", int'(if_a.out_data), 283);
    drain();

    // Back-to-back 128 blocks with out_ready high.
    send_samples(s128, 0, 8, 0);
    prev_last = last_acc_cyc;
    ready_cnt = 0;
    send_samples(s128, 0, 8, 0);
    check("s2_period_gap", first_acc_cyc - prev_last, 73);
    check("s2_ready_cycles", ready_cnt, 8);
    drain();

    // Saturation on the 9-bit instance.
    send_samples(s255, 0, 8, 0);
    wait_index(0);
    check("s3_sat_hi", int'(if_b.out_data), 255);
    drain();
    send_samples(s000, 0, 8, 0);
    wait_index(0);
    check("s3_sat_lo", int'(if_b.out_data), -256);
    drain();

    // Signed ramp, then hold X3 for 5 cycles.
    send_samples(sramp, 0, 8, 0);
    wait_index(0);
    check("s4_x0", int'(if_c.out_data), 10);
    wait_index(1);
    check("s4_x1", int'(if_c.out_data), -6);
    wait_index(2);
    tick();
    out_ready = 1'b0;
    wait_index(3);
    hold = int'(if_c.out_data);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s4_hold_data", int'(if_c.out_data), hold);
      check("s4_hold_index", int'(if_c.out_index), 3);
      check("s4_hold_valid", int'(if_c.out_valid), 1);
      check("s4_hold_in_ready", int'(if_c.in_ready), 0);
    end
    out_ready = 1'b1;
    drain();

    // Reset while computing X4.
    send_samples(sramp, 0, 8, 0);
    wait_index(3);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("s5_rst_valid", int'(if_a.out_valid), 0);
    check("s5_rst_in_ready", int'(if_a.in_ready), 0);
    tick();
    rst = 1'b0;
    #1 check("s5_rel_in_ready", int'(if_a.in_ready), 1);
    send_samples(s228, 0, 8, 0);
    wait_index(0);
    check("s5_x0", int'(if_a.out_data), 283);
    drain();

    // Enable frozen for 3 cycles mid-load.
    send_samples(s228, 0, 4, 0);
    en       = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd7;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("s6_en_in_ready", int'(if_a.in_ready), 0);
      check("s6_en_out_valid", int'(if_a.out_valid), 0);
      tick();
    end
    en = 1'b1;
    send_samples(s228, 4, 4, 0);
    wait_index(0);
    check("s6_x0", int'(if_a.out_data), 283);
    drain();

    // Random blocks with random gaps, stalls and enable drops.
    rand_mode = 1'b1;
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 8; i++) srnd[i] = int'($urandom_range(255));
      send_samples(srnd, 0, 8, 30);
    end
    rand_mode = 1'b0;
    en        = 1'b1;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
